// File: rtl/demux_rom_seq_pkg.sv
// Shared types and constants for the demux ROM sequencer: FSM state, ROM word layout
// and the ROM contents function.
package demux_rom_seq_pkg;
   localparam int DW  = 2;
   localparam int SW  = 2;
   localparam int NCH = 1 << SW;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [SW-1:0] sel;
      logic [DW-1:0] data;
   } word_t;

   // word[a] = {sel = a[1:0], data = a[aw-1:aw-2]}
   function automatic word_t rom_word(input logic [31:0] a, input int aw);
      logic [31:0] sh;
      sh            = a >> (aw - DW);
      rom_word.sel  = a[SW-1:0];
      rom_word.data = sh[DW-1:0];
   endfunction
endpackage

// File: rtl/demux_rom_sequencer_if.sv
// Control/stream bundle between the upstream controller (master) and the sequencer (slave).
interface demux_rom_seq_if #(parameter int AW = 4);
   import demux_rom_seq_pkg::*;

   logic          start;
   logic          loop;
   logic          hold;
   logic [DW-1:0] data_out;
   logic [SW-1:0] sel_out;
   logic          valid;
   logic [AW-1:0] addr;
   logic          busy;
   logic          done;

   modport master (output start, loop, hold,
                   input  data_out, sel_out, valid, addr, busy, done);
   modport slave  (input  start, loop, hold,
                   output data_out, sel_out, valid, addr, busy, done);
endinterface

// File: rtl/demux_rom_sequencer_rom_lut.sv
// Combinational ROM lookup: address -> {sel, data} word.
module rom_lut
   import demux_rom_seq_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic [AW-1:0] addr,
   output word_t         word
);
   always_comb word = rom_word(32'(addr), AW);
endmodule

// File: rtl/demux_rom_sequencer.sv
// Steps through the ROM LUT and presents one {sel, data} word per cycle to the demux,
// with start, hold (stall), loop and an end-of-run done pulse.
module demux_rom_sequencer
   import demux_rom_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   demux_rom_seq_if.slave bus
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic [SW-1:0] sel_q;
   logic          valid_q;
   logic          fin_q;
   word_t         rd;

   rom_lut #(.AW(AW)) u_rom (.addr(addr_q), .word(rd));

   // fin_q marks that the final word of a non-looping run has just been issued, so the
   // DONE state (and its done pulse) lands one cycle after that word with valid low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid_q <= 1'b0;
               if (bus.start) begin
                  state  <= RUN;
                  addr_q <= '0;
               end
            end
            RUN: begin
               if (fin_q) begin
                  state   <= DONE;
                  valid_q <= 1'b0;
                  fin_q   <= 1'b0;
               end else if (bus.hold) begin
                  valid_q <= 1'b0;
               end else begin
                  data_q  <= rd.data;
                  sel_q   <= rd.sel;
                  valid_q <= 1'b1;
                  if (addr_q == LAST) begin
                     addr_q <= '0;
                     fin_q  <= !bus.loop;
                  end else begin
                     addr_q <= addr_q + AW'(1);
                  end
               end
            end
            DONE: begin
               valid_q <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data_out = data_q;
   assign bus.sel_out  = sel_q;
   assign bus.valid    = valid_q;
   assign bus.addr     = addr_q;
   assign bus.busy     = (state != IDLE);
   assign bus.done     = (state == DONE);
endmodule
